// File: rtl/fire_disp_pkg.sv
// fire_disp_pkg: FSM state encodings, seven-segment glyphs and display decode helpers.
package fire_disp_pkg;
  typedef enum logic [1:0] {SAFE = 2'd0, ALM_ON = 2'd1, ALM_OFF = 2'd2, LATCHED = 2'd3} state_e;
  localparam logic [6:0] SEG_S     = 7'b0100100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_I     = 7'b1001111;
  localparam logic [6:0] SEG_R     = 7'b1111010;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  // Digit 0 is the leftmost character of each message.
  function automatic logic [6:0] glyph(input state_e s, input logic [1:0] d);
    logic [6:0] safe_g, fire_g;
    safe_g = d == 2'd0 ? SEG_S : d == 2'd1 ? SEG_A : d == 2'd2 ? SEG_F : SEG_E;
    fire_g = d == 2'd0 ? SEG_F : d == 2'd1 ? SEG_I : d == 2'd2 ? SEG_R : SEG_E;
    return s == SAFE ? safe_g : s == ALM_OFF ? SEG_BLANK : fire_g;
  endfunction
  function automatic logic [3:0] anode(input logic [1:0] d);
    return ~(4'b1000 >> d);
  endfunction
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: 2-FF synchroniser followed by a stable-level filter; the output follows
// the synchronised input only after it has differed for DEBOUNCE_CYC consecutive cycles.
module sync_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_0,
  input  logic async_i,
  output logic db_o
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic [1:0]    sync_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done;
  always_ff @(posedge clk or negedge rst_0) begin
    if (!rst_0) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], async_i};
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end
  always_comb begin
    done  = cnt_q == CW'(DEBOUNCE_CYC - 1);
    cnt_d = (sync_q[1] == db_q || done) ? '0 : cnt_q + 1'b1;
    db_d  = (sync_q[1] != db_q && done) ? sync_q[1] : db_q;
  end
  assign db_o = db_q;
endmodule

// File: rtl/fire_display_ctrl.sv
// fire_display_ctrl: fire alarm FSM with blinking/latched "FIrE" message on a scanned 4-digit display.
// Optional LAMP_TEST_EN adds a lamp_test input that lights every segment of the scanned digit.
module fire_display_ctrl
  import fire_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 100_000,
  parameter int BLINK_DIV    = 25_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_0,
  input  logic       fire_in,
  input  logic       ack,
`ifdef LAMP_TEST_EN
  input  logic       lamp_test,
`endif
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       alarm,
  output logic [1:0] state_o
);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  state_e        state_q, state_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [1:0]    digit_q, digit_d;
  logic [2:0]    ack_q;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          alarm_q, alarm_d;
  logic          fire_db, ack_p, lamp, scan_wrap, blink_tick;
  sync_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_fire_db (
    .clk    (clk),
    .rst_0  (rst_0),
    .async_i(fire_in),
    .db_o   (fire_db)
  );
`ifdef LAMP_TEST_EN
  logic [1:0] lamp_q;
  always_ff @(posedge clk or negedge rst_0) begin
    if (!rst_0) lamp_q <= '0;
    else        lamp_q <= {lamp_q[0], lamp_test};
  end
  assign lamp = lamp_q[1];
`else
  assign lamp = 1'b0;
`endif
  // ack_q[2] is the delayed copy of the synchronised level, used for edge detection.
  assign ack_p = ack_q[1] & ~ack_q[2];
  always_ff @(posedge clk or negedge rst_0) begin
    if (!rst_0) begin
      state_q <= SAFE;
      scan_q  <= '0;
      blink_q <= '0;
      digit_q <= '0;
      ack_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= 4'b1111;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      blink_q <= blink_d;
      digit_q <= digit_d;
      ack_q   <= {ack_q[1:0], ack};
      seg_q   <= seg_d;
      an_q    <= an_d;
      alarm_q <= alarm_d;
    end
  end
  always_comb begin
    scan_wrap  = scan_q == SW'(SCAN_DIV - 1);
    scan_d     = scan_wrap ? '0 : scan_q + 1'b1;
    digit_d    = scan_wrap ? digit_q + 1'b1 : digit_q;
    blink_tick = blink_q == BW'(BLINK_DIV - 1);
    // Blink counter idles at zero outside the blinking states, so entering ALM_ON starts a full half-period.
    blink_d    = ((state_q == ALM_ON || state_q == ALM_OFF) && !blink_tick) ? blink_q + 1'b1 : '0;
    state_d    = state_q;
    unique case (state_q)
      SAFE:    state_d = fire_db ? ALM_ON : SAFE;
      ALM_ON:  state_d = !fire_db ? LATCHED : blink_tick ? ALM_OFF : ALM_ON;
      ALM_OFF: state_d = !fire_db ? LATCHED : blink_tick ? ALM_ON : ALM_OFF;
      LATCHED: state_d = fire_db ? ALM_ON : ack_p ? SAFE : LATCHED;
    endcase
  end
  always_comb begin
    seg_d   = lamp ? 7'b0000000 : glyph(state_d, digit_d);
    an_d    = anode(digit_d);
    alarm_d = state_d == ALM_ON || state_d == ALM_OFF;
  end
  assign seg     = seg_q;
  assign an      = an_q;
  assign alarm   = alarm_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_fire_display_ctrl.sv
// tb_fire_display_ctrl: table-driven cycle vectors with a queue scoreboard checked on the falling edge.
module tb_fire_display_ctrl;
  localparam logic [1:0] SAFE_S = 2'd0, ON_S = 2'd1, OFF_S = 2'd2, LAT_S = 2'd3;
  typedef struct {
    logic       fire;
    logic       ack;
    int         n;
    logic [1:0] st;
    logic       alarm;
  } vec_t;
  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] st;
    logic       alarm;
    int         tag;
    int         cyc;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_0 = 1'b0;
  logic       fire_in = 1'b0;
  logic       ack = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       alarm;
  logic [1:0] state_o;
  logic       lamp_exp = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  exp_t       sb[$];
  vec_t       tbl[26];
`ifdef LAMP_TEST_EN
  logic lamp_test = 1'b0;
`endif
  fire_display_ctrl #(.SCAN_DIV(4), .BLINK_DIV(8), .DEBOUNCE_CYC(3)) dut (
    .clk      (clk),
    .rst_0    (rst_0),
    .fire_in  (fire_in),
    .ack      (ack),
`ifdef LAMP_TEST_EN
    .lamp_test(lamp_test),
`endif
    .seg      (seg),
    .an       (an),
    .alarm    (alarm),
    .state_o  (state_o)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] exp_seg(input logic [1:0] st, input int d);
    logic [27:0] m;
    if (lamp_exp) return 7'b0000000;
    m = st == SAFE_S ? 28'b0100100_0001000_0111000_0110000 :
        st == OFF_S  ? {4{7'b1111111}} : 28'b0111000_1001111_1111010_0110000;
    return m[27-7*d -: 7];
  endfunction
  function automatic logic [3:0] exp_an(input int d);
    logic [15:0] t;
    t = 16'b0111_1011_1101_1110;
    return t[15-4*d -: 4];
  endfunction
  task automatic push(input logic [1:0] st, input logic al, input int tag);
    exp_t e;
    int   d;
    d = (cyc / 4) % 4;
    e = '{exp_an(d), exp_seg(st, d), st, al, tag, cyc};
    sb.push_back(e);
  endtask
  task automatic push_reset(input int tag);
    exp_t e;
    e = '{4'b1111, 7'h7F, SAFE_S, 1'b0, tag, cyc};
    sb.push_back(e);
  endtask
  task automatic run_row(input vec_t v, input int tag);
    fire_in = v.fire;
    ack     = v.ack;
    for (int i = 0; i < v.n; i++) begin
      @(posedge clk);
      cyc++;
      push(v.st, v.alarm, tag);
      @(negedge clk);
    end
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if ({an, seg, state_o, alarm} !== {e.an, e.seg, e.st, e.alarm}) begin
        n_fail++;
        $display("FAIL row%0d cyc%0d: got an=%b seg=%b state=%0d alarm=%b, want an=%b seg=%b state=%0d alarm=%b",
                 e.tag, e.cyc, an, seg, state_o, alarm, e.an, e.seg, e.st, e.alarm);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0]  = '{1'b0, 1'b0, 16, SAFE_S, 1'b0};
    tbl[1]  = '{1'b1, 1'b0,  5, SAFE_S, 1'b0};
    tbl[2]  = '{1'b1, 1'b0,  1, ON_S,   1'b1};
    tbl[3]  = '{1'b1, 1'b0,  7, ON_S,   1'b1};
    tbl[4]  = '{1'b1, 1'b0,  1, OFF_S,  1'b1};
    tbl[5]  = '{1'b1, 1'b0,  7, OFF_S,  1'b1};
    tbl[6]  = '{1'b1, 1'b0,  1, ON_S,   1'b1};
    tbl[7]  = '{1'b1, 1'b1,  3, ON_S,   1'b1};
    tbl[8]  = '{1'b1, 1'b0,  4, ON_S,   1'b1};
    tbl[9]  = '{1'b1, 1'b0,  1, OFF_S,  1'b1};
    tbl[10] = '{1'b0, 1'b0,  5, OFF_S,  1'b1};
    tbl[11] = '{1'b0, 1'b0,  1, LAT_S,  1'b0};
    tbl[12] = '{1'b0, 1'b0, 16, LAT_S,  1'b0};
    tbl[13] = '{1'b0, 1'b1,  2, LAT_S,  1'b0};
    tbl[14] = '{1'b0, 1'b0,  1, SAFE_S, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 16, SAFE_S, 1'b0};
    tbl[16] = '{1'b1, 1'b0,  2, SAFE_S, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 12, SAFE_S, 1'b0};
    tbl[18] = '{1'b1, 1'b0,  3, SAFE_S, 1'b0};
    tbl[19] = '{1'b0, 1'b0,  2, SAFE_S, 1'b0};
    tbl[20] = '{1'b0, 1'b0,  3, ON_S,   1'b1};
    tbl[21] = '{1'b0, 1'b0,  1, LAT_S,  1'b0};
    tbl[22] = '{1'b1, 1'b0,  3, LAT_S,  1'b0};
    tbl[23] = '{1'b1, 1'b1,  2, LAT_S,  1'b0};
    tbl[24] = '{1'b1, 1'b0,  1, ON_S,   1'b1};
    tbl[25] = '{1'b1, 1'b0,  6, ON_S,   1'b1};
    push_reset(100);
    @(negedge clk);
    @(negedge clk);
    rst_0 = 1'b1;
    cyc   = 0;
    for (int r = 0; r < 26; r++) run_row(tbl[r], r);
    // Asynchronous reset in the middle of ALM_ON must clear the outputs before the next edge.
    @(posedge clk);
    #1 rst_0 = 1'b0;
    push_reset(101);
    @(negedge clk);
    @(negedge clk);
    rst_0 = 1'b1;
    cyc   = 0;
    run_row('{1'b1, 1'b0, 5, SAFE_S, 1'b0}, 102);
    run_row('{1'b1, 1'b0, 1, ON_S,   1'b1}, 103);
    run_row('{1'b1, 1'b0, 7, ON_S,   1'b1}, 104);
    run_row('{1'b1, 1'b0, 1, OFF_S,  1'b1}, 105);
`ifdef LAMP_TEST_EN
    lamp_test = 1'b1;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    lamp_exp = 1'b1;
    run_row('{1'b1, 1'b0, 4, OFF_S, 1'b1}, 106);
`endif
    @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
